// File: rtl/qkd_est_pkg.sv
// Shared types and defaults for the QKD estimator blocks.
package qkd_est_pkg;

    localparam int unsigned E1_COEF_AMP_DEF = 24;
    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned DIV_W_DEF       = CNT_W_DEF + E1_COEF_AMP_DEF;

    // Dividend width of the e1 division: error count followed by the fraction bits.
    function automatic int unsigned div_w(input int unsigned cnt_w, input int unsigned coef_amp);
        return cnt_w + coef_amp;
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StAcc,
        StDiv,
        StRnd,
        StDone
    } e1_state_e;

endpackage

// File: rtl/seq_udiv.sv
// Serial restoring unsigned divider: one quotient bit per cycle, MSB first.
// o_done is high in the cycle of the final step; o_quot/o_rem already show the final
// values in that cycle and keep showing them while the divider is idle.
module seq_udiv #(
    parameter int unsigned DVD_W = 56,
    parameter int unsigned DVS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quot,
    output logic [DVS_W-1:0] o_rem
);

    localparam int unsigned CNT_BITS = $clog2(DVD_W + 1);

    // q_q starts as the dividend and fills with quotient bits from the right.
    logic [DVD_W-1:0]    q_q, q_d;
    logic [DVS_W-1:0]    rem_q, rem_d;
    logic [DVS_W-1:0]    dvs_q, dvs_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [DVS_W:0]      rem_sh;
    logic [DVS_W-1:0]    rem_sub;
    logic                take;
    logic                done;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep if non-negative.
    always_comb begin
        rem_sh  = {rem_q, q_q[DVD_W-1]};
        take    = (rem_sh >= {1'b0, dvs_q});
        // The true difference is below the divisor, so the low bits are exact.
        rem_sub = rem_sh[DVS_W-1:0] - dvs_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done    = 1'b0;
        if (i_abort) begin
            busy_d = 1'b0;
        end else if (i_start) begin
            q_d    = i_dividend;
            rem_d  = '0;
            dvs_d  = i_divisor;
            cnt_d  = CNT_BITS'(DVD_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            q_d   = {q_q[DVD_W-2:0], take};
            rem_d = take ? rem_sub : rem_sh[DVS_W-1:0];
            cnt_d = cnt_q - CNT_BITS'(1);
            if (cnt_q == CNT_BITS'(1)) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign o_done = done;
    assign o_quot = q_d;
    assign o_rem  = rem_d;

endmodule

// File: rtl/e1_est.sv
// Phase-error estimator: e1 = err_cnt * 2^E1_COEF_AMP / tot_cnt over one block.
// Build option: define E1_EST_ROUND_EN to round the quotient half up (adds the RND state);
// otherwise the quotient is truncated.
module e1_est
    import qkd_est_pkg::*;
#(
    parameter int unsigned E1_COEF_AMP = E1_COEF_AMP_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_bit_vld,
    input  logic        i_bit_a,
    input  logic        i_bit_b,
    input  logic        i_end,
    output logic        o_busy,
    output logic [31:0] o_e1,
    output logic        o_e1_vld,
    output logic        o_e1_error
);

    localparam int unsigned DIV_W = div_w(CNT_W, E1_COEF_AMP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    e1_state_e        state_q, state_d;
    logic [CNT_W-1:0] tot_q, tot_d, err_q, err_d;
    logic [CNT_W-1:0] tot_inc, err_inc;
    logic             sat;
    logic             error_q, error_d;
    logic [31:0]      e1_q, e1_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             div_start, div_abort, div_done;
    logic [DIV_W-1:0] div_quot;
    logic [CNT_W-1:0] div_rem;
    // Quotient never exceeds 2^E1_COEF_AMP, so the bits above 31 stay zero.
    logic             unused_quot_hi;

    assign unused_quot_hi = ^div_quot[DIV_W-1:32];

`ifdef E1_EST_ROUND_EN
    logic rnd_bit;
    // Extra quotient bit decides round-half-up.
    assign rnd_bit = ({div_rem, 1'b0} >= {1'b0, tot_q});
`else
    logic unused_rem;
    assign unused_rem = ^div_rem;
`endif

    // Counter update for this cycle's bit (saturating) and FSM next state / outputs.
    always_comb begin
        tot_inc   = tot_q;
        err_inc   = err_q;
        sat       = 1'b0;
        if (i_bit_vld) begin
            if (tot_q == CNT_MAX) sat = 1'b1;
            else                  tot_inc = tot_q + CNT_W'(1);
            if (i_bit_a ^ i_bit_b) begin
                if (err_q == CNT_MAX) sat = 1'b1;
                else                  err_inc = err_q + CNT_W'(1);
            end
        end
        state_d   = state_q;
        tot_d     = tot_q;
        err_d     = err_q;
        error_d   = error_q;
        e1_d      = e1_q;
        vld_d     = 1'b0;
        busy_d    = busy_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        if (i_start) begin
            // Start wins over everything, including a pending end or running division.
            state_d   = StAcc;
            tot_d     = '0;
            err_d     = '0;
            error_d   = 1'b0;
            busy_d    = 1'b1;
            div_abort = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAcc: begin
                    tot_d = tot_inc;
                    err_d = err_inc;
                    if (sat) error_d = 1'b1;
                    if (i_end) begin
                        if (tot_inc == '0) begin
                            e1_d    = '0;
                            error_d = 1'b1;
                            vld_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StDone;
                        end else begin
                            div_start = 1'b1;
                            state_d   = StDiv;
                        end
                    end
                end
                StDiv: begin
                    if (div_done) begin
`ifdef E1_EST_ROUND_EN
                        state_d = StRnd;
`else
                        e1_d    = div_quot[31:0];
                        vld_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StDone;
`endif
                    end
                end
`ifdef E1_EST_ROUND_EN
                StRnd: begin
                    e1_d    = div_quot[31:0] + 32'(rnd_bit);
                    vld_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end
`endif
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tot_q   <= '0;
            err_q   <= '0;
            error_q <= 1'b0;
            e1_q    <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tot_q   <= tot_d;
            err_q   <= err_d;
            error_q <= error_d;
            e1_q    <= e1_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    seq_udiv #(
        .DVD_W(DIV_W),
        .DVS_W(CNT_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .i_start   (div_start),
        .i_abort   (div_abort),
        .i_dividend({err_inc, {E1_COEF_AMP{1'b0}}}),
        .i_divisor (tot_inc),
        .o_done    (div_done),
        .o_quot    (div_quot),
        .o_rem     (div_rem)
    );

    assign o_busy     = busy_q;
    assign o_e1       = e1_q;
    assign o_e1_vld   = vld_q;
    assign o_e1_error = error_q;

endmodule

// File: tb/tb_e1_est.sv
// Self-checking bench for e1_est (default parameters; follows E1_EST_ROUND_EN if defined).
module tb_e1_est;

    localparam int AMP = 24;
`ifdef E1_EST_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    // i_end seen at t: first look is t+1, strobe expected at t+W+1 (+1 when rounding).
    localparam int LAT = 32 + AMP + 1 + RND;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_bit_vld, i_bit_a, i_bit_b, i_end;
    logic        o_busy, o_e1_vld, o_e1_error;
    logic [31:0] o_e1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    e1_est dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_bit_vld (i_bit_vld),
        .i_bit_a   (i_bit_a),
        .i_bit_b   (i_bit_b),
        .i_end     (i_end),
        .o_busy    (o_busy),
        .o_e1      (o_e1),
        .o_e1_vld  (o_e1_vld),
        .o_e1_error(o_e1_error)
    );

    typedef struct {
        int          nbits;
        int          nerr;
        bit          joint;
        logic [31:0] e1;
        bit          err;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: e1 = err * 2^AMP / tot, optionally rounded half up.
    function automatic logic [31:0] model_e1(input longint unsigned err, input longint unsigned tot);
        longint unsigned num, q, r;
        if (tot == 0) return 32'd0;
        num = err << AMP;
        q   = num / tot;
        r   = num % tot;
        if (RND != 0 && 2 * r >= tot) q++;
        return q[31:0];
    endfunction

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Mismatches are placed on the last nerr bits; joint puts i_end on the last bit.
    task automatic send_block(input int n, input int nerr, input bit joint);
        for (int i = 0; i < n; i++) begin
            i_bit_vld = 1'b1;
            i_bit_a   = 1'($urandom);
            i_bit_b   = i_bit_a ^ (i >= n - nerr);
            i_end     = joint && (i == n - 1);
            tick();
        end
        i_bit_vld = 1'b0;
        if (!(joint && n > 0)) begin
            i_end = 1'b1;
            tick();
        end
        i_end = 1'b0;
    endtask

    // Called one cycle after i_end was sampled.
    task automatic wait_result(input string name, input int exp_lat, input logic [31:0] exp_e1,
                               input bit exp_err);
        int lat;
        bit seen, busy_ok;
        logic [31:0] e1_seen;
        lat     = 1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (lat <= exp_lat + 10) begin
            if (o_e1_vld) begin
                seen = 1'b1;
                break;
            end
            if (!o_busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check({name, " latency"}, seen ? lat : -1, exp_lat);
        check({name, " busy before strobe"}, busy_ok, 1);
        check({name, " e1"}, o_e1, exp_e1);
        check({name, " error"}, o_e1_error, exp_err);
        check({name, " busy at strobe"}, o_busy, 0);
        e1_seen = o_e1;
        tick();
        check({name, " strobe one cycle"}, o_e1_vld, 0);
        check({name, " e1 held"}, o_e1, e1_seen);
    endtask

    initial begin
        vec_t tbl[7];
        int   vld_cnt;

        tbl[0] = '{1000, 25, 1'b0, 32'd419430,                      1'b0, LAT};
        tbl[1] = '{3,    2,  1'b0, (RND != 0) ? 32'd11184811 : 32'd11184810, 1'b0, LAT};
        tbl[2] = '{8,    8,  1'b0, 32'h0100_0000,                   1'b0, LAT};
        tbl[3] = '{8,    0,  1'b0, 32'd0,                           1'b0, LAT};
        tbl[4] = '{0,    0,  1'b0, 32'd0,                           1'b1, 1};
        tbl[5] = '{4,    1,  1'b1, 32'd4194304,                     1'b0, LAT};
        tbl[6] = '{10,   1,  1'b0, (RND != 0) ? 32'd1677722 : 32'd1677721,   1'b0, LAT};

        rst = 1'b1; i_start = 1'b0; i_bit_vld = 1'b0; i_bit_a = 1'b0; i_bit_b = 1'b0;
        i_end = 1'b0;
        repeat (3) tick();
        check("reset e1", o_e1, 0);
        check("reset vld", o_e1_vld, 0);
        check("reset busy", o_busy, 0);
        check("reset error", o_e1_error, 0);
        rst = 1'b0;
        tick();

        // Table of directed blocks.
        for (int k = 0; k < 7; k++) begin
            pulse_start();
            check($sformatf("vec%0d busy after start", k), o_busy, 1);
            send_block(tbl[k].nbits, tbl[k].nerr, tbl[k].joint);
            wait_result($sformatf("vec%0d", k), tbl[k].lat, tbl[k].e1, tbl[k].err);
        end

        // Error from the empty block is cleared by the next start.
        pulse_start();
        check("error cleared by start", o_e1_error, 0);
        send_block(0, 0, 1'b0);
        wait_result("empty again", 1, 32'd0, 1'b1);

        // Abort a running division with i_start at t+20.
        pulse_start();
        send_block(12, 5, 1'b0);
        vld_cnt = 0;
        repeat (19) begin
            if (o_e1_vld) vld_cnt++;
            tick();
        end
        pulse_start();
        if (o_e1_vld) vld_cnt++;
        check("abort no strobe", vld_cnt, 0);
        check("abort busy", o_busy, 1);
        send_block(10, 1, 1'b0);
        wait_result("after abort", LAT, model_e1(1, 10), 1'b0);

        // i_start and i_end together: start wins and the block restarts.
        pulse_start();
        send_block(5, 3, 1'b1 == 1'b0);
        // send_block above already issued i_end; restart with start+end together instead.
        wait_result("pre start+end", LAT, model_e1(3, 5), 1'b0);
        pulse_start();
        send_block(6, 4, 1'b0 ^ 1'b0);
        // discard: issue start+end during the next block's accumulation
        tick();
        pulse_start();
        i_bit_vld = 1'b1; i_bit_a = 1'b1; i_bit_b = 1'b0;
        tick();
        i_bit_vld = 1'b0;
        i_start = 1'b1; i_end = 1'b1;
        tick();
        i_start = 1'b0; i_end = 1'b0;
        check("start+end busy", o_busy, 1);
        check("start+end no strobe", o_e1_vld, 0);
        send_block(2, 1, 1'b0);
        wait_result("start+end", LAT, model_e1(1, 2), 1'b0);

        // Reset mid-division.
        pulse_start();
        send_block(5, 5, 1'b0);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid-div e1", o_e1, 0);
        check("rst mid-div vld", o_e1_vld, 0);
        check("rst mid-div busy", o_busy, 0);
        check("rst mid-div error", o_e1_error, 0);
        i_bit_vld = 1'b1; i_end = 1'b1; i_bit_a = 1'b1; i_bit_b = 1'b0;
        tick();
        i_bit_vld = 1'b0; i_end = 1'b0;
        vld_cnt = 0;
        repeat (LAT + 10) begin
            if (o_e1_vld || o_busy) vld_cnt++;
            tick();
        end
        check("idle after rst", vld_cnt, 0);

        // Randomized blocks against the reference model.
        for (int k = 0; k < 15; k++) begin
            int  n, thr, tot, err;
            bit  joint, mism;
            n     = $urandom_range(1, 200);
            thr   = $urandom_range(0, 100);
            joint = 1'($urandom);
            tot   = 0;
            err   = 0;
            // Bits and i_end outside ACC must be ignored.
            i_bit_vld = 1'b1; i_end = 1'b1; i_bit_a = 1'b0; i_bit_b = 1'b1;
            tick();
            check($sformatf("rand%0d idle ignore", k), {o_e1_vld, o_busy}, 2'b00);
            i_bit_vld = 1'b0; i_end = 1'b0;
            pulse_start();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_bit_vld = 1'b0;
                    i_bit_a   = 1'($urandom);
                    i_bit_b   = 1'($urandom);
                    tick();
                end
                mism      = ($urandom_range(0, 99) < thr);
                i_bit_vld = 1'b1;
                i_bit_a   = 1'($urandom);
                i_bit_b   = i_bit_a ^ mism;
                i_end     = joint && (i == n - 1);
                tot++;
                err += int'(mism);
                tick();
            end
            i_bit_vld = 1'b0;
            if (!joint) begin
                i_end = 1'b1;
                tick();
            end
            i_end = 1'b0;
            wait_result($sformatf("rand%0d n=%0d e=%0d", k, tot, err), LAT, model_e1(err, tot),
                        1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
